// File: rtl/iterative_alu.sv
// iterative_alu: RV32IM execute unit. Base integer ops and branch compares
// finish in one cycle; multiply/divide/remainder run one bit per cycle on a
// shared shift register pair behind a valid/ready handshake.
module iterative_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL    = 5'd2,  OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8,  OP_AND  = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_REM  = 5'd16, OP_REMU = 5'd17, OP_BEQ    = 5'd18, OP_BNE   = 5'd19;
  localparam logic [4:0] OP_BLT  = 5'd20, OP_BGE  = 5'd21, OP_BLTU   = 5'd22, OP_BGEU  = 5'd23;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t          state_r, state_nxt_s;
  logic [4:0]      op_r;
  logic [W-1:0]    hi_r, lo_r, mcand_r;    // accumulator/remainder, multiplier/quotient, multiplicand/divisor
  logic            neg_r;                  // magnitude result must be negated at the end
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    result_r;
  logic            bcond_r;

  logic            accept_s, in_ready_s, is_mul_s, is_div_s;
  logic            a_neg_s, b_neg_s, neg_s, div_zero_s, div_ovf_s, div_special_s;
  logic [W-1:0]    a_mag_s, b_mag_s, special_res_s;
  logic [W:0]      single_s;
  logic [W:0]      mul_sum_s;
  logic [2*W-1:0]  mul_prod_s, mul_fin_s;
  logic [W:0]      div_shift_s, div_trial_s;
  logic [W-1:0]    div_rem_s, div_quo_s, div_fin_s;
  logic            load_res_s;
  logic [W-1:0]    res_nxt_s;
  logic            bcond_nxt_s;

  // Single-cycle ops: returns {bcond, result}.
  function automatic logic [W:0] single_op(input logic [4:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0]       r;
    logic               c;
    logic [SHAMT_W-1:0] sh;
    r  = {W{1'b0}};
    c  = 1'b0;
    sh = b[SHAMT_W-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(W-1){1'b0}}, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_BEQ:  begin r = a - b; c = (a == b); end
      OP_BNE:  begin r = a - b; c = (a != b); end
      OP_BLT:  begin r = a - b; c = ($signed(a) <  $signed(b)); end
      OP_BGE:  begin r = a - b; c = ($signed(a) >= $signed(b)); end
      OP_BLTU: begin r = a - b; c = (a <  b); end
      OP_BGEU: begin r = a - b; c = (a >= b); end
      default: begin r = {W{1'b0}}; c = 1'b0; end
    endcase
    return {c, r};
  endfunction

  assign in_ready_s = (state_r == S_IDLE) || ((state_r == S_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Decode the incoming op: class, operand signs/magnitudes and div special cases.
  always_comb begin
    is_mul_s = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
    is_div_s = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
    a_neg_s  = alu_in_1[W-1] && ((alu_op == OP_MULH) || (alu_op == OP_MULHSU) ||
                                 (alu_op == OP_DIV)  || (alu_op == OP_REM));
    b_neg_s  = alu_in_2[W-1] && ((alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM));
    a_mag_s  = a_neg_s ? -alu_in_1 : alu_in_1;
    b_mag_s  = b_neg_s ? -alu_in_2 : alu_in_2;
    // Remainder follows the dividend; quotient/product follow the sign xor.
    neg_s    = (alu_op == OP_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
    div_zero_s = (alu_in_2 == {W{1'b0}});
    div_ovf_s  = ((alu_op == OP_DIV) || (alu_op == OP_REM)) &&
                 (alu_in_1 == {1'b1, {(W-1){1'b0}}}) && (alu_in_2 == {W{1'b1}});
    div_special_s = is_div_s && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      special_res_s = ((alu_op == OP_DIV) || (alu_op == OP_DIVU)) ? {W{1'b1}} : alu_in_1;
    end else begin
      special_res_s = (alu_op == OP_DIV) ? alu_in_1 : {W{1'b0}};
    end
    single_s = single_op(alu_op, alu_in_1, alu_in_2);
  end

  // One shift-add multiply step and one restoring-divide step, plus sign fix-up.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    mul_prod_s  = {mul_sum_s, lo_r[W-1:1]};
    mul_fin_s   = neg_r ? -mul_prod_s : mul_prod_s;
    div_shift_s = {hi_r, lo_r[W-1]};
    div_trial_s = div_shift_s - {1'b0, mcand_r};
    div_rem_s   = div_trial_s[W] ? div_shift_s[W-1:0] : div_trial_s[W-1:0];
    div_quo_s   = {lo_r[W-2:0], ~div_trial_s[W]};
    if ((op_r == OP_DIV) || (op_r == OP_DIVU)) begin
      div_fin_s = neg_r ? -div_quo_s : div_quo_s;
    end else begin
      div_fin_s = neg_r ? -div_rem_s : div_rem_s;
    end
  end

  // Next-state and result-load decision.
  always_comb begin
    state_nxt_s = state_r;
    load_res_s  = 1'b0;
    res_nxt_s   = result_r;
    bcond_nxt_s = bcond_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_nxt_s = S_MUL;
          end else if (is_div_s && !div_special_s) begin
            state_nxt_s = S_DIV;
          end else begin
            state_nxt_s = S_DONE;
            load_res_s  = 1'b1;
            res_nxt_s   = div_special_s ? special_res_s : single_s[W-1:0];
            bcond_nxt_s = div_special_s ? 1'b0 : single_s[W];
          end
        end else if ((state_r == S_DONE) && out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_DONE;
          load_res_s  = 1'b1;
          res_nxt_s   = (op_r == OP_MUL) ? mul_fin_s[W-1:0] : mul_fin_s[2*W-1:W];
          bcond_nxt_s = 1'b0;
        end else begin
          state_nxt_s = S_MUL;
        end
      end
      S_DIV: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_DONE;
          load_res_s  = 1'b1;
          res_nxt_s   = div_fin_s;
          bcond_nxt_s = 1'b0;
        end else begin
          state_nxt_s = S_DIV;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Operand capture, iteration datapath and registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= 5'd0;
      hi_r     <= {W{1'b0}};
      lo_r     <= {W{1'b0}};
      mcand_r  <= {W{1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      result_r <= {W{1'b0}};
      bcond_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r  <= alu_op;
        neg_r <= neg_s;
        hi_r  <= {W{1'b0}};
        if (is_mul_s) begin
          lo_r    <= b_mag_s;
          mcand_r <= a_mag_s;
          cnt_r   <= CNT_INIT;
        end else if (is_div_s && !div_special_s) begin
          lo_r    <= a_mag_s;
          mcand_r <= b_mag_s;
          cnt_r   <= CNT_INIT;
        end
      end else if (state_r == S_MUL) begin
        hi_r  <= mul_prod_s[2*W-1:W];
        lo_r  <= mul_prod_s[W-1:0];
        cnt_r <= cnt_r - CNT_LAST;
      end else if (state_r == S_DIV) begin
        hi_r  <= div_rem_s;
        lo_r  <= div_quo_s;
        cnt_r <= cnt_r - CNT_LAST;
      end
      if (load_res_s) begin
        result_r <= res_nxt_s;
        bcond_r  <= bcond_nxt_s;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = (state_r == S_DONE);
  assign busy       = (state_r == S_MUL) || (state_r == S_DIV);
  assign alu_result = result_r;
  assign alu_bcond  = bcond_r;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu (DATA_WIDTH = 32).
module tb_iterative_alu;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_in_1, alu_in_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        alu_bcond;
  logic        busy;

  int tests  = 0;
  int failed = 0;
  int lat;
  int busy_cyc;

  iterative_alu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .alu_bcond(alu_bcond), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a single edge; returns in cycle 1 after accept.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    alu_in_1 = a;
    alu_in_2 = b;
    tick();
    in_valid = 1'b0;
    alu_in_1 = 32'hDEAD_BEEF;
    alu_in_2 = 32'h1234_5678;
  endtask

  // Issue and wait (bounded) for out_valid; lat = cycle at which it appears.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    issue(op, a, b);
    l = 1;
    busy_cyc = busy ? 1 : 0;
    while (!out_valid && l < 100) begin
      tick();
      l++;
      if (busy) busy_cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_op = 5'd0; alu_in_1 = 32'd0; alu_in_2 = 32'd0;
    out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_result",    alu_result,     32'd0);
    check("rst_bcond",     32'(alu_bcond), 32'd0);
    reset = 1'b0;
    tick();

    do_op(5'd0, 32'd5, 32'd7, lat);
    check("add_lat", 32'(lat), 32'd1);
    check("add_res", alu_result, 32'd12);
    check("add_bcond", 32'(alu_bcond), 32'd0);
    do_op(5'd7, 32'h8000_0000, 32'h0000_0024, lat);
    check("sra_lat", 32'(lat), 32'd1);
    check("sra_res", alu_result, 32'hF800_0000);

    do_op(5'd11, 32'h8000_0000, 32'h8000_0000, lat);
    check("mulh_lat", 32'(lat), 32'd33);
    check("mulh_busy_cycles", 32'(busy_cyc), 32'd32);
    check("mulh_busy_done", 32'(busy), 32'd0);
    check("mulh_res", alu_result, 32'h4000_0000);
    do_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mulhu_lat", 32'(lat), 32'd33);
    check("mulhu_res", alu_result, 32'hFFFF_FFFE);
    do_op(5'd10, 32'hFFFF_FFFD, 32'd7, lat);
    check("mul_res", alu_result, 32'hFFFF_FFEB);

    do_op(5'd14, 32'd7, 32'd0, lat);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_res", alu_result, 32'hFFFF_FFFF);
    do_op(5'd16, 32'd7, 32'd0, lat);
    check("rem0_lat", 32'(lat), 32'd1);
    check("rem0_res", alu_result, 32'd7);
    do_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divovf_lat", 32'(lat), 32'd1);
    check("divovf_res", alu_result, 32'h8000_0000);
    do_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("removf_lat", 32'(lat), 32'd1);
    check("removf_res", alu_result, 32'd0);
    do_op(5'd14, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_lat", 32'(lat), 32'd33);
    check("div_res", alu_result, 32'hFFFF_FFFD);
    do_op(5'd16, 32'hFFFF_FFF9, 32'd2, lat);
    check("rem_res", alu_result, 32'hFFFF_FFFF);

    do_op(5'd20, 32'hFFFF_FFFF, 32'd1, lat);
    check("blt_bcond", 32'(alu_bcond), 32'd1);
    check("blt_res", alu_result, 32'hFFFF_FFFE);
    do_op(5'd22, 32'hFFFF_FFFF, 32'd1, lat);
    check("bltu_bcond", 32'(alu_bcond), 32'd0);
    do_op(5'd18, 32'd9, 32'd9, lat);
    check("beq_bcond", 32'(alu_bcond), 32'd1);
    check("beq_res", alu_result, 32'd0);

    // Backpressure on a long op, then a same-cycle accept on release.
    issue(5'd15, 32'd100, 32'd7);
    check("divu_in_ready_busy", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_res", alu_result, 32'd14);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_res", alu_result, 32'd14);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    do_op(5'd0, 32'd3, 32'd4, lat);
    check("release_add_lat", 32'(lat), 32'd1);
    check("release_add_res", alu_result, 32'd7);

    // Reset in the middle of a MULHU.
    issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", alu_result, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    do_op(5'd0, 32'd1, 32'd1, lat);
    check("post_rst_add_lat", 32'(lat), 32'd1);
    check("post_rst_add_res", alu_result, 32'd2);
    tick();
    check("post_rst_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/iterative_alu.md
# iterative_alu

Parametrised multi-cycle ALU for the RV32IM datapath. It executes base integer ops and branch compares in one cycle and M-extension multiply/divide/remainder iteratively, one bit per cycle. It sits between the decode/operand stage and writeback behind a valid/ready handshake, so the controller stalls only while a long op is in flight.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥ 8
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from alu_in_2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- alu_op  in  5  op code (see Operation)
- alu_in_1  in  DATA_WIDTH  operand A (rs1)
- alu_in_2  in  DATA_WIDTH  operand B (rs2/imm)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- alu_result  out  DATA_WIDTH  registered result
- alu_bcond  out  1  registered branch-taken flag
- busy  out  1  high in MUL or DIV state

## Operation
- Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU, 18 BEQ, 19 BNE, 20 BLT, 21 BGE, 22 BLTU, 23 BGEU; 24–31 → result 0, bcond 0, single-cycle.
- Arithmetic is modulo 2^DATA_WIDTH. Shifts use alu_in_2[SHAMT_W-1:0] only. SRA replicates alu_in_1 MSB. SLT/SLTU yield 1 or 0 in bit 0.
- MUL: low DATA_WIDTH bits of the product. MULH/MULHSU/MULHU: high DATA_WIDTH bits of the 2·DATA_WIDTH product, signed×signed, signed×unsigned, unsigned×unsigned respectively.
- DIV/REM round toward zero; remainder takes dividend's sign. Divide by zero: quotient all-ones, remainder = alu_in_1. Signed overflow (A = −2^(W−1), B = −1): quotient = A, remainder 0. Both special cases are detected at accept and complete as single-cycle ops.
- Branch ops: alu_bcond = compare result; alu_result = alu_in_1 − alu_in_2. Non-branch ops: alu_bcond = 0.
- Operands and op are captured at accept; input changes afterwards are ignored.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + accept, single-cycle op → DONE, result registered.
  - IDLE + accept, mul op → MUL; div op (non-special) → DIV; iteration counter loaded with DATA_WIDTH.
  - MUL/DIV: one shift-add / restoring-subtract step per cycle; on the last step → DONE, final result registered.
  - DONE: out_valid = 1; alu_result and alu_bcond are stable until the handshake. On out_ready the state goes to IDLE, or directly to the next op's state if a new accept occurs in the same cycle.
- in_ready = (state == IDLE) || (state == DONE && out_ready).

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, alu_result 0, alu_bcond 0, counter 0.
- Single-cycle ops and div special cases: out_valid in the cycle after accept (latency 1).
- Mul/div: out_valid DATA_WIDTH+1 cycles after accept (33 for the default).
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- out_ready low: the result holds indefinitely and in_ready stays 0.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded and never presented.
- in_valid in MUL/DIV: ignored (in_ready = 0). No op is lost or duplicated.

## Test plan
- ADD 5 + 7 with out_ready = 1 → out_valid 1 cycle later, alu_result 12, alu_bcond 0. Then SRA 0x80000000 by 0x24 (shamt 4) → 0xF8000000.
- MULH 0x80000000 × 0x80000000 → 0x40000000 at cycle 33, busy high cycles 1–32. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL −3 × 7 → 0xFFFFFFEB.
- DIV 7 / 0 → 0xFFFFFFFF, REM 7 / 0 → 7, DIV 0x80000000 / −1 → 0x80000000, REM same → 0, each at latency 1. DIV −7 / 2 → −3, REM → −1.
- BLT −1 vs 1 → bcond 1. BLTU same operands → bcond 0. BEQ 9 vs 9 → bcond 1, alu_result 0.
- Backpressure: DIVU 100 / 7 with out_ready low for 5 cycles after out_valid → result 14 held stable, in_ready 0. Release → a new ADD is accepted in the same cycle.
- Reset asserted at cycle 10 of a MULHU → out_valid 0 immediately. A following ADD 1 + 1 → 2 at latency 1.
